// File: rtl/btb_update_queue_pkg.sv
// Shared types for the BTB training path: commit-side resolved branches,
// BTB write records and the queue entry format.
package btb_update_queue_pkg;

    typedef enum logic [2:0] {
        CF_NONE,
        CF_BRANCH,
        CF_JUMP,
        CF_CALL,
        CF_RETURN,
        CF_JUMP_REG
    } cf_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] target;
        cf_t         cf;
        logic        mispredict;
    } resolved_branch_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] target;
        cf_t         cf;
    } btb_update_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        cf_t         cf;
    } btb_entry_t;

    // BTB entries are word-indexed, so two PCs alias when bits [31:2] agree.
    function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

    function automatic btb_entry_t to_entry(input resolved_branch_t r);
        btb_entry_t e;
        e.pc     = r.pc;
        e.target = r.target;
        e.cf     = r.cf;
        return e;
    endfunction

endpackage

// File: rtl/btb_update_queue_fifo.sv
// Circular FIFO with a 2-wide ordered push, 1-wide pop and in-place
// overwrite of the most recently written entry.
module sync_fifo_overwrite #(
    parameter int  DEPTH = 8,
    parameter type dtype = logic [7:0]
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 push,
    input  dtype                       push_data0,
    input  dtype                       push_data1,
    input  logic                       ovr,
    input  dtype                       ovr_data,
    input  logic                       pop,
    output dtype                       head_data,
    output dtype                       tail_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    dtype          mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] tail_last;

    assign tail_last = tail - AW'(1);
    assign head_data = mem[head];
    assign tail_data = mem[tail_last];

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop);
            tail  <= tail + AW'(push[0]) + AW'(push[1]);
            count <= count + CW'(push[0]) + CW'(push[1]) - CW'(pop);
        end
    end

    // Storage is not reset; writes are suppressed in the reset cycle so a
    // mid-stream reset leaves nothing half-written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (ovr)
                mem[tail_last] <= ovr_data;
            if (push[0])
                mem[tail] <= push_data0;
            if (push[1])
                mem[tail + AW'(push[0])] <= push_data1;
        end
    end

endmodule

// File: rtl/btb_update_queue.sv
// Filters committed mispredicts into BTB write requests, merges aliasing
// updates, and drains one write per cycle when the BTB is ready.
module btb_update_queue
    import btb_update_queue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DROP_CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  resolved_branch_t [1:0]     resolved,
    input  logic                       btb_ready,
    output btb_update_t                update,
    output logic                       queue_empty,
    output logic [DROP_CNT_W-1:0]      drop_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]     count;
    logic [CW-1:0]     free0;
    logic [CW-1:0]     free1;
    btb_entry_t        head_e;
    btb_entry_t        tail_e;
    btb_entry_t        ovr_data;
    logic [1:0]        push;
    logic              ovr;
    logic              pop;
    logic              cand0;
    logic              cand1;
    logic              c0;
    logic              tail_live;
    logic              hit0;
    logic              hit1;
    logic              last_live;
    logic [31:0]       last_pc;
    logic              drop0;
    logic              drop1;
    logic [DROP_CNT_W:0] drop_sum;

    always_comb begin
        push     = '0;
        ovr      = 1'b0;
        ovr_data = tail_e;
        drop0    = 1'b0;
        drop1    = 1'b0;

        pop   = (count != '0) && btb_ready;
        cand0 = resolved[0].valid && resolved[0].mispredict;
        cand1 = resolved[1].valid && resolved[1].mispredict;
        c0    = cand0 && !(cand1 && same_line(resolved[0].pc, resolved[1].pc));

        // An entry being popped this cycle is leaving and cannot absorb a merge.
        tail_live = count > CW'(pop);
        free0     = CW'(DEPTH) - count + CW'(pop);

        hit0 = c0 && tail_live && same_line(resolved[0].pc, tail_e.pc);
        if (hit0) begin
            ovr             = 1'b1;
            ovr_data.target = resolved[0].target;
            ovr_data.cf     = resolved[0].cf;
        end else if (c0) begin
            if (free0 != '0) push[0] = 1'b1;
            else             drop0   = 1'b1;
        end

        // Slot 1 sees slot 0's effect on the tail; a slot-0 push can never
        // alias slot 1 because same-line pairs already suppressed slot 0.
        last_pc   = push[0] ? resolved[0].pc : tail_e.pc;
        last_live = tail_live || push[0];
        free1     = free0 - CW'(push[0]);

        hit1 = cand1 && last_live && same_line(resolved[1].pc, last_pc);
        if (hit1) begin
            ovr             = 1'b1;
            ovr_data.target = resolved[1].target;
            ovr_data.cf     = resolved[1].cf;
        end else if (cand1) begin
            if (free1 != '0) push[1] = 1'b1;
            else             drop1   = 1'b1;
        end
    end

    sync_fifo_overwrite #(
        .DEPTH (DEPTH),
        .dtype (btb_entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data0 (to_entry(resolved[0])),
        .push_data1 (to_entry(resolved[1])),
        .ovr        (ovr),
        .ovr_data   (ovr_data),
        .pop        (pop),
        .head_data  (head_e),
        .tail_data  (tail_e),
        .count      (count)
    );

    assign drop_sum = {1'b0, drop_count} + (DROP_CNT_W+1)'(drop0) + (DROP_CNT_W+1)'(drop1);

    always_ff @(posedge clk) begin
        if (rst)
            drop_count <= '0;
        else if (drop_sum[DROP_CNT_W])
            drop_count <= '1;
        else
            drop_count <= drop_sum[DROP_CNT_W-1:0];
    end

    assign queue_empty = (count == '0);

    always_comb begin
        update       = '0;
        update.valid = pop;
        if (!queue_empty) begin
            update.pc     = head_e.pc;
            update.target = head_e.target;
            update.cf     = head_e.cf;
        end
    end

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed bench for btb_update_queue with a scoreboard queue of expected
// BTB writes and an independent output monitor.
module tb_btb_update_queue;
    import btb_update_queue_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    resolved_branch_t [1:0] resolved;
    logic                   btb_ready;
    btb_update_t            update;
    logic                   queue_empty;
    logic [15:0]            drop_count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        cf_t         cf;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    btb_update_queue #(.DEPTH(8), .DROP_CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .resolved    (resolved),
        .btb_ready   (btb_ready),
        .update      (update),
        .queue_empty (queue_empty),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    function automatic resolved_branch_t rb(input logic v, input logic [31:0] pc,
                                            input logic [31:0] t, input cf_t cf,
                                            input logic m);
        resolved_branch_t r;
        r.valid = v; r.pc = pc; r.target = t; r.cf = cf; r.mispredict = m;
        return r;
    endfunction

    task automatic expect_update(input logic [31:0] pc, input logic [31:0] t, input cf_t cf);
        exp_t e;
        e.pc = pc; e.target = t; e.cf = cf;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        resolved[0] = '0;
        resolved[1] = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Every presented write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && update.valid === 1'b1) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_update: got pc=%h target=%h, required no update",
                         update.pc, update.target);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (update.pc !== e.pc || update.target !== e.target || update.cf !== e.cf) begin
                    mismatched++;
                    $display("FAIL update_data: got pc=%h target=%h cf=%0d, required pc=%h target=%h cf=%0d",
                             update.pc, update.target, update.cf, e.pc, e.target, e.cf);
                end
            end
        end
    end

    initial begin
        int n;
        rst       = 1'b1;
        btb_ready = 1'b1;
        idle();
        repeat (2) step();
        chk("reset_empty", 32'(queue_empty), 32'd1);
        chk("reset_valid", 32'(update.valid), 32'd0);
        chk("reset_pc", update.pc, 32'h0);
        chk("reset_drops", 32'(drop_count), 32'd0);
        rst = 1'b0;
        step();

        // Single mispredict: visible one cycle after enqueue, gone the next.
        resolved[0] = rb(1'b1, 32'h8000_1000, 32'h8000_2000, CF_BRANCH, 1'b1);
        expect_update(32'h8000_1000, 32'h8000_2000, CF_BRANCH);
        step();
        idle();
        chk("single_valid", 32'(update.valid), 32'd1);
        chk("single_pc", update.pc, 32'h8000_1000);
        step();
        chk("single_empty", 32'(queue_empty), 32'd1);

        // Filter: correctly predicted slot 0 ignored; CF_NONE mispredict kept.
        resolved[0] = rb(1'b1, 32'h8000_0020, 32'h0000_1234, CF_BRANCH, 1'b0);
        resolved[1] = rb(1'b1, 32'h8000_0010, 32'h8000_0500, CF_NONE, 1'b1);
        expect_update(32'h8000_0010, 32'h8000_0500, CF_NONE);
        step();
        idle();
        repeat (2) step();
        chk("filter_drops", 32'(drop_count), 32'd0);
        chk("filter_empty", 32'(queue_empty), 32'd1);

        // Same-cycle then tail dedup while the BTB is busy.
        btb_ready   = 1'b0;
        resolved[0] = rb(1'b1, 32'h8000_0040, 32'h0000_0100, CF_JUMP, 1'b1);
        resolved[1] = rb(1'b1, 32'h8000_0040, 32'h0000_0200, CF_JUMP, 1'b1);
        step();
        chk("dedup_same_target", update.target, 32'h0000_0200);
        chk("dedup_hold_valid", 32'(update.valid), 32'd0);
        resolved[0] = rb(1'b1, 32'h8000_0040, 32'h0000_0300, CF_CALL, 1'b1);
        resolved[1] = '0;
        step();
        idle();
        chk("dedup_tail_target", update.target, 32'h0000_0300);
        chk("dedup_tail_cf", 32'(update.cf), 32'(CF_CALL));
        expect_update(32'h8000_0040, 32'h0000_0300, CF_CALL);
        btb_ready = 1'b1;
        step();
        chk("dedup_one_entry", 32'(queue_empty), 32'd1);

        // Overflow: 10 candidates into 8 slots, last pair dropped.
        btb_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            resolved[0] = rb(1'b1, 32'h8001_0000 + 32'(k*16), 32'h8001_1000 + 32'(k*16), CF_BRANCH, 1'b1);
            resolved[1] = rb(1'b1, 32'h8001_0008 + 32'(k*16), 32'h8001_1008 + 32'(k*16), CF_JUMP_REG, 1'b1);
            if (k < 4) begin
                expect_update(32'h8001_0000 + 32'(k*16), 32'h8001_1000 + 32'(k*16), CF_BRANCH);
                expect_update(32'h8001_0008 + 32'(k*16), 32'h8001_1008 + 32'(k*16), CF_JUMP_REG);
            end
            step();
        end
        idle();
        chk("ovf_drops", 32'(drop_count), 32'd2);
        chk("ovf_not_empty", 32'(queue_empty), 32'd0);
        chk("ovf_hold_valid", 32'(update.valid), 32'd0);
        chk("ovf_hold_pc", update.pc, 32'h8001_0000);

        // Full with pop: one new candidate is accepted and drains ninth.
        btb_ready   = 1'b1;
        resolved[0] = rb(1'b1, 32'h8002_0000, 32'h8002_1000, CF_RETURN, 1'b1);
        expect_update(32'h8002_0000, 32'h8002_1000, CF_RETURN);
        step();
        idle();
        n = 0;
        while (!queue_empty && n < 30) begin
            step();
            n++;
        end
        chk("full_pop_drain_cycles", 32'(n), 32'd8);
        chk("full_pop_drops", 32'(drop_count), 32'd2);

        // Reset mid-stream discards four pending entries.
        btb_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            resolved[0] = rb(1'b1, 32'h8003_0000 + 32'(k*16), 32'h8003_1000, CF_BRANCH, 1'b1);
            resolved[1] = rb(1'b1, 32'h8003_0008 + 32'(k*16), 32'h8003_2000, CF_JUMP, 1'b1);
            step();
        end
        idle();
        chk("pre_reset_not_empty", 32'(queue_empty), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_reset_valid", 32'(update.valid), 32'd0);
        chk("mid_reset_empty", 32'(queue_empty), 32'd1);
        chk("mid_reset_drops", 32'(drop_count), 32'd0);
        btb_ready = 1'b1;
        repeat (10) step();

        resolved[0] = rb(1'b1, 32'h8004_0000, 32'h8004_0100, CF_JUMP, 1'b1);
        expect_update(32'h8004_0000, 32'h8004_0100, CF_JUMP);
        step();
        idle();
        repeat (3) step();
        chk("post_reset_empty", 32'(queue_empty), 32'd1);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/btb_update_queue.md
Name: btb_update_queue

Overview:
- Back-end producer for BTB training. Collects up to two resolved, committed control-flow instructions per cycle from the commit stage and keeps only those the BTB got wrong.
- Buffers them in a small FIFO and drains one btb_update_t per cycle into the BTB write port, honouring btb_ready.
- Sits between commit and the fetch-side BTB. Dropping an update under overflow is architecturally safe because the BTB is only a hint.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- DROP_CNT_W, 16, width of the saturating dropped-update counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- resolved  input  resolved_branch_t [1:0]  commit slots; slot 0 older; fields valid, pc, target, cf, mispredict
- btb_ready  input  1  BTB accepts writes (low during BTB init sweep)
- update  output  btb_update_t  fields valid, pc, target, cf; one write per cycle
- queue_empty  output  1  no pending entries
- drop_count  output  DROP_CNT_W  saturating count of discarded updates

Behaviour:
- Filter: slot i is a candidate iff resolved[i].valid & resolved[i].mispredict.
  - A mispredict with cf == CF_NONE is still enqueued; it clears a stale BTB entry.
- Same-cycle dedup: if both slots are candidates and pc[31:2] matches, enqueue only slot 1.
- Tail dedup: if a candidate's pc[31:2] equals the most recently enqueued entry still in the FIFO, overwrite that entry in place (target, cf). No new slot is used and order is unchanged.
  - With two candidates, slot 0's write is visible to slot 1's tail comparison.
- Dequeue:
  - update.valid = ~empty & btb_ready.
  - update.pc, target and cf come from the head entry.
  - The head pops in any cycle where update.valid = 1.
  - Output is combinational from the FIFO head register; no extra pipeline stage.
- Latency: an entry enqueued in cycle N is presented at the earliest in cycle N+1.
- Free-slot accounting: free = DEPTH - count + pop, with pop evaluated in the same cycle.
  - Candidates are accepted in order: slot 0, then slot 1.
  - A candidate that finds no free slot is dropped. drop_count increments by 1 or 2 and saturates at all-ones.
  - Tail-dedup overwrites never drop.
- Full with pop: one incoming entry is accepted in the same cycle.
- btb_ready low: no pops; enqueues continue until full, then drops.
  - update.valid = 0 and update.pc/target/cf hold the head.
- Pointers: head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- Reset:
  - Clears head, tail, count and drop_count. queue_empty = 1, update.valid = 0; other update fields are 0.
  - Entry storage is not cleared.
  - Reset asserted mid-stream discards all pending entries with no partial write.
- No flush input: everything arriving is already committed, so pipeline flushes do not affect the queue.

Decomposition:
- Shared cpu package:
  - resolved_branch_t
  - btb_update_t (existing)
  - cf_t enum: CF_NONE, CF_BRANCH, CF_JUMP, CF_CALL, CF_RETURN, CF_JUMP_REG
- Sub-module sync_fifo_overwrite: parameterised DEPTH/dtype FIFO with a 2-wide push port, a 1-wide pop port and tail-entry overwrite. The top level holds the filter, the dedup compare and the drop counter.

Test Plan:
- Single mispredict: slot0 pc=0x80001000, target=0x80002000, CF_BRANCH, btb_ready=1 at cycle 0 -> update.valid=1 at cycle 1 with those values; queue_empty=1 at cycle 2.
- Filter: slot0 valid with mispredict=0, slot1 pc=0x80000010 with mispredict=1 -> exactly one update (0x80000010); drop_count stays 0.
- Dedup:
  - Both slots pc=0x80000040, targets 0x100 and 0x200 -> one update with target 0x200.
  - Next cycle slot0 pc=0x80000040, target 0x300 while that entry is still queued (btb_ready=0) -> still one entry, target 0x300.
- Overflow: btb_ready=0, 5 cycles of two distinct candidates with DEPTH=8 -> count=8, drop_count=2. Then btb_ready=1 -> exactly 8 updates in FIFO order on consecutive cycles.
- Full with pop: FIFO full, btb_ready=1, one new candidate -> accepted and delivered 9th; drop_count unchanged.
- Reset mid-stream: 4 entries queued, rst for 1 cycle -> update.valid=0 from the next cycle, queue_empty=1, drop_count=0; no stale entries emerge afterwards.
